// File: rtl/flags_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flags_pkg
//  Description : Shared constants for the NZCV status flags unit: ALU
//                command codes, flag bit positions and the reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
package flags_pkg;

    // ALU command encodings as presented by the EXE stage
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;   // also CMP
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;   // also TST
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    // Bit positions inside the {N,Z,C,V} nibble
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] FLAGS_RST = 4'b0000;

endpackage : flags_pkg
`default_nettype wire

// File: rtl/status_flags_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : status_flags_unit_if
//  Description : Pipeline-side signal bundle of the status flags unit.
//                master = pipeline/driver side, slave = flags unit side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface status_flags_unit_if #(
    parameter int WIDTH = 32
);
    logic             exe_valid;
    logic             exe_s;
    logic             exe_flush;
    logic             freeze;
    logic [3:0]       exe_cmd;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             id_uses_cond;
    logic             exc_entry;
    logic             exc_return;
    logic [3:0]       status_out;
    logic [3:0]       shadow_out;
    logic             flags_stall;

    modport master (
        output exe_valid, exe_s, exe_flush, freeze, exe_cmd, op_a, op_b,
               id_uses_cond, exc_entry, exc_return,
        input  status_out, shadow_out, flags_stall
    );

    modport slave (
        input  exe_valid, exe_s, exe_flush, freeze, exe_cmd, op_a, op_b,
               id_uses_cond, exc_entry, exc_return,
        output status_out, shadow_out, flags_stall
    );

endinterface : status_flags_unit_if
`default_nettype wire

// File: rtl/status_flags_unit_flag_gen.sv
`default_nettype none
// ============================================================================
//  Module      : flag_gen
//  Description : Purely combinational {N,Z,C,V} generator for one ALU
//                command. valid_o is low for unrecognised commands so the
//                caller can suppress the write.
//  Revision    : 1.0 - initial release
// ============================================================================
module flag_gen
    import flags_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic [3:0]       cmd_i,
    input  wire logic [WIDTH-1:0] a_i,
    input  wire logic [WIDTH-1:0] b_i,
    input  wire logic             c_i,
    input  wire logic             v_i,
    output logic      [3:0]       flags_o,
    output logic                  valid_o
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_opb;     // second adder operand (inverted for subtract)
    logic             w_arith;

    // Select the result; subtract is a + ~b + carry-in so C is NOT borrow
    always_comb begin
        w_sum   = '0;
        w_res   = '0;
        w_opb   = b_i;
        w_arith = 1'b0;
        valid_o = 1'b1;
        case (cmd_i)
            CMD_ADD: begin
                w_arith = 1'b1;
                w_sum   = {1'b0, a_i} + {1'b0, b_i};
            end
            CMD_ADC: begin
                w_arith = 1'b1;
                w_sum   = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, c_i};
            end
            CMD_SUB: begin
                w_arith = 1'b1;
                w_opb   = ~b_i;
                w_sum   = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
            end
            CMD_SBC: begin
                w_arith = 1'b1;
                w_opb   = ~b_i;
                w_sum   = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, c_i};
            end
            CMD_AND: w_res = a_i & b_i;
            CMD_ORR: w_res = a_i | b_i;
            CMD_EOR: w_res = a_i ^ b_i;
            CMD_MOV: w_res = b_i;
            CMD_MVN: w_res = ~b_i;
            default: valid_o = 1'b0;
        endcase
        if (w_arith) begin
            w_res = w_sum[WIDTH-1:0];
        end
    end

    // Logical ops carry C and V through unchanged
    always_comb begin
        flags_o         = {1'b0, 1'b0, c_i, v_i};
        flags_o[FLAG_N] = w_res[WIDTH-1];
        flags_o[FLAG_Z] = (w_res == '0);
        if (w_arith) begin
            flags_o[FLAG_C] = w_sum[WIDTH];
            flags_o[FLAG_V] = (a_i[WIDTH-1] == w_opb[WIDTH-1]) &&
                              (w_res[WIDTH-1] != a_i[WIDTH-1]);
        end
    end

endmodule : flag_gen
`default_nettype wire

// File: rtl/status_flags_unit.sv
`default_nettype none
// ============================================================================
//  Module      : status_flags_unit
//  Description : Architectural NZCV status register with exception shadow
//                copy and ID-stage flag hazard detection.
//                Build option STATUS_FORWARD_EN: forward the next status
//                value combinationally and never stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module status_flags_unit
    import flags_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    status_flags_unit_if.slave bus
);

    logic [3:0] status_q, status_d;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] w_gen_flags;
    logic       w_cmd_ok;
    logic       w_wr;

    assign w_wr = bus.exe_valid & bus.exe_s & ~bus.exe_flush & ~bus.freeze;

    flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .cmd_i   (bus.exe_cmd),
        .a_i     (bus.op_a),
        .b_i     (bus.op_b),
        .c_i     (status_q[FLAG_C]),
        .v_i     (status_q[FLAG_V]),
        .flags_o (w_gen_flags),
        .valid_o (w_cmd_ok)
    );

    // Next status/shadow: return beats a write; entry saves the post-write
    // value, and is ignored when a return happens in the same cycle
    always_comb begin
        status_d = status_q;
        shadow_d = shadow_q;
        if (!bus.freeze) begin
            if (bus.exc_return) begin
                status_d = shadow_q;
            end else if (w_wr && w_cmd_ok) begin
                status_d = w_gen_flags;
            end
            if (bus.exc_entry && !bus.exc_return) begin
                shadow_d = status_d;
            end
        end
    end

    // Status and shadow registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= FLAGS_RST;
            shadow_q <= FLAGS_RST;
        end else begin
            status_q <= status_d;
            shadow_q <= shadow_d;
        end
    end

    assign bus.shadow_out = shadow_q;

`ifdef STATUS_FORWARD_EN
    // The condition checker sees this cycle's outcome, so no hazard exists
    assign bus.status_out  = status_d;
    assign bus.flags_stall = 1'b0;
`else
    // Registered status only; ID waits while an S instruction sits in EXE
    assign bus.status_out  = status_q;
    assign bus.flags_stall = bus.id_uses_cond & bus.exe_valid &
                             bus.exe_s & ~bus.exe_flush;
`endif

endmodule : status_flags_unit
`default_nettype wire

// File: tb/tb_status_flags_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_status_flags_unit
//  Description : Directed self-checking bench for status_flags_unit.
//                Honours STATUS_FORWARD_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_status_flags_unit;

    localparam logic [3:0] C_MOV = 4'b0001;
    localparam logic [3:0] C_MVN = 4'b1001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_ADC = 4'b0011;
    localparam logic [3:0] C_SUB = 4'b0100;
    localparam logic [3:0] C_SBC = 4'b0101;
    localparam logic [3:0] C_AND = 4'b0110;
    localparam logic [3:0] C_ORR = 4'b0111;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    status_flags_unit_if #(.WIDTH(32)) bus ();

    status_flags_unit #(
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.exe_valid    = 1'b0;
        bus.exe_s        = 1'b0;
        bus.exe_flush    = 1'b0;
        bus.freeze       = 1'b0;
        bus.exe_cmd      = 4'b0000;
        bus.op_a         = 32'h0;
        bus.op_b         = 32'h0;
        bus.id_uses_cond = 1'b0;
        bus.exc_entry    = 1'b0;
        bus.exc_return   = 1'b0;
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        bus.exe_valid = 1'b1;
        bus.exe_s     = 1'b1;
        bus.exe_cmd   = cmd;
        bus.op_a      = a;
        bus.op_b      = b;
    endtask

    // Advance past the next rising edge, then return inputs to idle
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        idle();
        #12;
        chk("rst_status", bus.status_out, 4'b0000);
        chk("rst_shadow", bus.shadow_out, 4'b0000);
        chk("rst_stall", {3'b000, bus.flags_stall}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 0x80000000 + 0x80000000 = 0 with carry and overflow
        drive(C_ADD, 32'h8000_0000, 32'h8000_0000);
        tick();
        chk("add_cv", bus.status_out, 4'b0111);

        // MVN 0 -> all ones, C/V kept; entry saves it
        drive(C_MVN, 32'h0, 32'h0);
        bus.exc_entry = 1'b1;
        tick();
        chk("mvn_status", bus.status_out, 4'b1011);
        chk("mvn_shadow", bus.shadow_out, 4'b1011);

        // Asynchronous reset in mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_status", bus.status_out, 4'b0000);
        chk("async_rst_shadow", bus.shadow_out, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD overflow, with an ID instruction using a condition
        drive(C_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        bus.id_uses_cond = 1'b1;
        #1;
`ifdef STATUS_FORWARD_EN
        chk("fwd_stall", {3'b000, bus.flags_stall}, 4'b0000);
        chk("fwd_status", bus.status_out, 4'b1001);
`else
        chk("haz_stall", {3'b000, bus.flags_stall}, 4'b0001);
        chk("haz_status_old", bus.status_out, 4'b0000);
`endif
        tick();
        bus.id_uses_cond = 1'b1;
        #1;
        chk("haz_stall_clear", {3'b000, bus.flags_stall}, 4'b0000);
        chk("add_ovf", bus.status_out, 4'b1001);

        // SUB equal: Z=1, C=1 (no borrow)
        drive(C_SUB, 32'd5, 32'd5);
        tick();
        chk("sub_eq", bus.status_out, 4'b0110);

        // AND zero keeps C
        drive(C_AND, 32'h0, 32'h0);
        tick();
        chk("and_zero", bus.status_out, 4'b0110);

        // ORR negative result, C kept
        drive(C_ORR, 32'h8000_0000, 32'h0);
        tick();
        chk("orr_neg", bus.status_out, 4'b1010);

        // Suppressed writes (MOV 0 would give 0110)
        drive(C_MOV, 32'h0, 32'h0);
        bus.exe_s = 1'b0;
        tick();
        chk("supp_s0", bus.status_out, 4'b1010);
        drive(C_MOV, 32'h0, 32'h0);
        bus.exe_flush = 1'b1;
        tick();
        chk("supp_flush", bus.status_out, 4'b1010);
        drive(C_MOV, 32'h0, 32'h0);
        bus.freeze = 1'b1;
        tick();
        chk("supp_freeze", bus.status_out, 4'b1010);
        drive(4'b1111, 32'h0, 32'h0);
        tick();
        chk("supp_undef", bus.status_out, 4'b1010);

        // ADC with C=1: 0xFFFFFFFF + 2 + 1 carries out; entry same cycle
        drive(C_ADC, 32'hFFFF_FFFF, 32'h0000_0002);
        bus.exc_entry = 1'b1;
        tick();
        chk("adc_status", bus.status_out, 4'b0010);
        chk("adc_shadow", bus.shadow_out, 4'b0010);

        // SBC with C=1 behaves as SUB: 0 - 1 borrows
        drive(C_SBC, 32'h0, 32'h1);
        tick();
        chk("sbc_borrow", bus.status_out, 4'b1000);

        // SBC with C=0: 5 - 2 - 1 = 2, no borrow
        drive(C_SBC, 32'd5, 32'd2);
        tick();
        chk("sbc_cin0", bus.status_out, 4'b0010);

        drive(C_MVN, 32'h0, 32'h0);
        tick();
        chk("mvn2", bus.status_out, 4'b1010);
        chk("shadow_hold", bus.shadow_out, 4'b0010);

        // Exception return restores the shadow
        bus.exc_return = 1'b1;
        tick();
        chk("ret_status", bus.status_out, 4'b0010);
        chk("ret_shadow", bus.shadow_out, 4'b0010);

        // Entry + return + commit together: return wins
        drive(C_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        tick();
        chk("add_ovf2", bus.status_out, 4'b1001);
        drive(C_MVN, 32'h0, 32'h0);
        bus.exc_entry  = 1'b1;
        bus.exc_return = 1'b1;
        tick();
        chk("both_status", bus.status_out, 4'b0010);
        chk("both_shadow", bus.shadow_out, 4'b0010);

        // Freeze blocks return and entry
        drive(C_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        tick();
        bus.freeze     = 1'b1;
        bus.exc_entry  = 1'b1;
        bus.exc_return = 1'b1;
        tick();
        chk("frz_status", bus.status_out, 4'b1001);
        chk("frz_shadow", bus.shadow_out, 4'b0010);

        // Negative overflow: 0x80000000 + 0xFFFFFFFF = 0x7FFFFFFF, C=1, V=1
        drive(C_ADD, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        chk("add_negovf", bus.status_out, 4'b0011);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_status_flags_unit
`default_nettype wire
